// File: rtl/cam_table_ctrl.sv
// Table manager sitting in front of a CAM: one request at a time, tracks
// entry occupancy in a bitmap, allocates the lowest free slot on insert.
module cam_table_ctrl #(
  parameter int DATA_WIDTH = 64,
  parameter int ADDR_WIDTH = 5
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  req_valid,
  output logic                  req_ready,
  input  logic [1:0]            req_op,
  input  logic [DATA_WIDTH-1:0] req_key,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [1:0]            resp_status,
  output logic [ADDR_WIDTH-1:0] resp_addr,
  output logic [ADDR_WIDTH:0]   count,
  output logic [ADDR_WIDTH-1:0] cam_write_addr,
  output logic [DATA_WIDTH-1:0] cam_write_data,
  output logic                  cam_write_delete,
  output logic                  cam_write_enable,
  output logic [DATA_WIDTH-1:0] cam_compare_data,
  input  logic                  cam_write_busy,
  input  logic                  cam_match,
  input  logic [ADDR_WIDTH-1:0] cam_match_addr
);

  localparam int ENTRIES = 2**ADDR_WIDTH;

  localparam logic [1:0] OP_LOOKUP = 2'd0;
  localparam logic [1:0] OP_INSERT = 2'd1;
  localparam logic [1:0] OP_DELETE = 2'd2;

  localparam logic [1:0] ST_OK       = 2'd0;
  localparam logic [1:0] ST_NOTFOUND = 2'd1;
  localparam logic [1:0] ST_EXISTS   = 2'd2;
  localparam logic [1:0] ST_FULL     = 2'd3;

  typedef enum logic [2:0] {IDLE, CMP, EVAL, ISSUE, SETTLE, WAIT, RESP} state_t;

  state_t                  state, next_state;
  logic [1:0]              op_reg;
  logic [DATA_WIDTH-1:0]   key_reg;
  logic [ENTRIES-1:0]      valid_map;
  logic [ADDR_WIDTH-1:0]   free_addr;
  logic                    full;

  logic                    load_req, load_write, set_resp, commit;
  logic [ADDR_WIDTH-1:0]   write_addr_d;
  logic [1:0]              resp_status_d;
  logic [ADDR_WIDTH-1:0]   resp_addr_d;

  assign cam_compare_data = key_reg;
  assign req_ready        = (state == IDLE) && !cam_write_busy && !rst;
  assign full             = (count == (ADDR_WIDTH+1)'(ENTRIES));

  // Lowest-index clear bit; descending scan so the lowest index wins.
  always_comb begin
    free_addr = '0;
    for (int i = ENTRIES-1; i >= 0; i--)
      if (!valid_map[i]) free_addr = ADDR_WIDTH'(i);
  end

  always_ff @(posedge clk) begin
    if (rst) state <= IDLE;
    else     state <= next_state;
  end

  always_comb begin
    next_state       = state;
    load_req         = 1'b0;
    load_write       = 1'b0;
    set_resp         = 1'b0;
    commit           = 1'b0;
    write_addr_d     = '0;
    resp_status_d    = ST_OK;
    resp_addr_d      = '0;
    cam_write_enable = 1'b0;
    case (state)
      IDLE: if (req_valid && req_ready) begin
        load_req   = 1'b1;
        next_state = CMP;
      end
      // Match outputs lag cam_compare_data by one cycle.
      CMP: next_state = EVAL;
      EVAL: begin
        next_state = RESP;
        case (op_reg)
          OP_LOOKUP: begin
            set_resp      = 1'b1;
            resp_status_d = cam_match ? ST_OK : ST_NOTFOUND;
            resp_addr_d   = cam_match ? cam_match_addr : '0;
          end
          OP_INSERT: begin
            if (cam_match) begin
              set_resp      = 1'b1;
              resp_status_d = ST_EXISTS;
              resp_addr_d   = cam_match_addr;
            end else if (full) begin
              set_resp      = 1'b1;
              resp_status_d = ST_FULL;
            end else begin
              load_write   = 1'b1;
              write_addr_d = free_addr;
              next_state   = ISSUE;
            end
          end
          OP_DELETE: begin
            if (!cam_match) begin
              set_resp      = 1'b1;
              resp_status_d = ST_NOTFOUND;
            end else begin
              load_write   = 1'b1;
              write_addr_d = cam_match_addr;
              next_state   = ISSUE;
            end
          end
          default: begin
            set_resp      = 1'b1;
            resp_status_d = ST_FULL;
          end
        endcase
      end
      ISSUE: if (!cam_write_busy && !rst) begin
        cam_write_enable = 1'b1;
        next_state       = SETTLE;
      end
      // CAM may take a cycle to raise busy after the write strobe.
      SETTLE: next_state = WAIT;
      WAIT: if (!cam_write_busy) begin
        commit        = 1'b1;
        set_resp      = 1'b1;
        resp_status_d = ST_OK;
        resp_addr_d   = cam_write_addr;
        next_state    = RESP;
      end
      RESP: if (resp_valid && resp_ready) next_state = IDLE;
      default: next_state = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      op_reg           <= '0;
      key_reg          <= '0;
      valid_map        <= '0;
      count            <= '0;
      resp_valid       <= 1'b0;
      resp_status      <= '0;
      resp_addr        <= '0;
      cam_write_addr   <= '0;
      cam_write_data   <= '0;
      cam_write_delete <= 1'b0;
    end else begin
      if (load_req) begin
        op_reg  <= req_op;
        key_reg <= req_key;
      end
      if (load_write) begin
        cam_write_addr   <= write_addr_d;
        cam_write_data   <= key_reg;
        cam_write_delete <= (op_reg == OP_DELETE);
      end
      if (set_resp) begin
        resp_status <= resp_status_d;
        resp_addr   <= resp_addr_d;
      end
      // Guard on the bitmap so count tracks popcount even if the CAM disagrees.
      if (commit) begin
        if (cam_write_delete) begin
          valid_map[cam_write_addr] <= 1'b0;
          if (valid_map[cam_write_addr]) count <= count - 1'b1;
        end else begin
          valid_map[cam_write_addr] <= 1'b1;
          if (!valid_map[cam_write_addr]) count <= count + 1'b1;
        end
      end
      resp_valid <= (state == RESP) && !(resp_valid && resp_ready);
    end
  end

endmodule

// File: tb/tb_cam_table_ctrl.sv
// Directed bench for cam_table_ctrl with a small behavioural CAM model.
`timescale 1ns/1ps
module tb_cam_table_ctrl;
  localparam int DW = 64;
  localparam int AW = 5;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          req_valid = 1'b0;
  logic          req_ready;
  logic [1:0]    req_op = '0;
  logic [DW-1:0] req_key = '0;
  logic          resp_valid;
  logic          resp_ready = 1'b1;
  logic [1:0]    resp_status;
  logic [AW-1:0] resp_addr;
  logic [AW:0]   count;
  logic [AW-1:0] cam_write_addr;
  logic [DW-1:0] cam_write_data;
  logic          cam_write_delete, cam_write_enable;
  logic [DW-1:0] cam_compare_data;
  logic          cam_write_busy, cam_match;
  logic [AW-1:0] cam_match_addr;

  cam_table_ctrl #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW)) dut (
    .clk(clk), .rst(rst), .req_valid(req_valid), .req_ready(req_ready),
    .req_op(req_op), .req_key(req_key), .resp_valid(resp_valid),
    .resp_ready(resp_ready), .resp_status(resp_status), .resp_addr(resp_addr),
    .count(count), .cam_write_addr(cam_write_addr), .cam_write_data(cam_write_data),
    .cam_write_delete(cam_write_delete), .cam_write_enable(cam_write_enable),
    .cam_compare_data(cam_compare_data), .cam_write_busy(cam_write_busy),
    .cam_match(cam_match), .cam_match_addr(cam_match_addr)
  );

  always #5 clk = ~clk;

  // CAM model: 16-cycle init after reset, 3-cycle busy per write, 1-cycle match.
  logic [DW-1:0] ent_key [32];
  logic          ent_v   [32];
  int            busy_cnt = 0;
  int            we_cnt = 0;
  assign cam_write_busy = (busy_cnt != 0);

  always @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < 32; i++) ent_v[i] <= 1'b0;
      busy_cnt       <= 16;
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
    end else begin
      if (busy_cnt > 0) busy_cnt <= busy_cnt - 1;
      if (cam_write_enable) begin
        ent_v[cam_write_addr]   <= !cam_write_delete;
        ent_key[cam_write_addr] <= cam_write_data;
        busy_cnt                <= 3;
      end
      cam_match      <= 1'b0;
      cam_match_addr <= '0;
      for (int i = 31; i >= 0; i--)
        if (ent_v[i] && ent_key[i] == cam_compare_data) begin
          cam_match      <= 1'b1;
          cam_match_addr <= AW'(i);
        end
    end
  end

  always @(posedge clk) if (cam_write_enable) we_cnt <= we_cnt + 1;

  int n_chk = 0;
  int n_pass = 0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
  endtask

  task automatic do_req(input logic [1:0] op, input logic [DW-1:0] key, input int hold,
                        output logic [1:0] st, output logic [AW-1:0] ad, output int lat);
    int n;
    logic stable;
    st = '0; ad = '0; lat = 0;
    @(negedge clk);
    req_valid = 1'b1; req_op = op; req_key = key; resp_ready = (hold == 0);
    n = 0;
    while (!req_ready && n < 200) begin @(negedge clk); n++; end
    if (!req_ready) begin
      check("accept_timeout", req_ready, 1);
      req_valid = 1'b0; resp_ready = 1'b1;
      return;
    end
    @(posedge clk); #1 req_valid = 1'b0;
    @(negedge clk);
    while (!resp_valid && lat < 200) begin @(posedge clk); lat++; @(negedge clk); end
    if (!resp_valid) begin
      check("resp_timeout", resp_valid, 1);
      resp_ready = 1'b1;
      return;
    end
    st = resp_status; ad = resp_addr;
    if (hold > 0) begin
      stable = 1'b1;
      repeat (hold) begin
        @(negedge clk);
        if (!resp_valid || resp_status != st || resp_addr != ad || req_ready) stable = 1'b0;
      end
      check("resp_hold_stable", stable, 1);
      resp_ready = 1'b1;
    end
    @(posedge clk); #1;
  endtask

  logic [1:0]    st;
  logic [AW-1:0] ad;
  int            lat, we0;
  logic          ok;

  initial begin
    // Reset and CAM initialisation window
    repeat (3) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    check("reset_count", count, 0);
    check("reset_resp_valid", resp_valid, 0);
    check("reset_resp_status", resp_status, 0);
    ok = 1'b1;
    repeat (16) begin
      if (req_ready || count != 0) ok = 1'b0;
      @(negedge clk);
    end
    check("init_ready_low", ok, 1);
    check("init_ready_high", req_ready, 1);

    // First insert and lookup latency
    we0 = we_cnt;
    do_req(2'd1, 64'hA5, 0, st, ad, lat);
    check("ins_a5_status", st, 0);
    check("ins_a5_addr", ad, 0);
    check("ins_a5_count", count, 1);
    check("ins_a5_writes", we_cnt - we0, 1);
    do_req(2'd0, 64'hA5, 0, st, ad, lat);
    check("lkp_a5_status", st, 0);
    check("lkp_a5_addr", ad, 0);
    check("lkp_a5_latency", lat, 3);

    // Duplicate insert
    we0 = we_cnt;
    do_req(2'd1, 64'hA5, 0, st, ad, lat);
    check("dup_status", st, 2);
    check("dup_addr", ad, 0);
    check("dup_writes", we_cnt - we0, 0);
    check("dup_count", count, 1);

    // Fill remaining 31 slots
    ok = 1'b1;
    for (int i = 1; i < 32; i++) begin
      do_req(2'd1, 64'h100 + 64'(i), 0, st, ad, lat);
      if (st != 2'd0 || ad != AW'(i)) ok = 1'b0;
    end
    check("fill_all_ok", ok, 1);
    check("fill_count", count, 32);
    we0 = we_cnt;
    do_req(2'd1, 64'h999, 0, st, ad, lat);
    check("full_status", st, 3);
    check("full_addr", ad, 0);
    check("full_writes", we_cnt - we0, 0);
    check("full_count", count, 32);

    // Free slot 7 and reuse it
    do_req(2'd2, 64'h107, 0, st, ad, lat);
    check("del7_status", st, 0);
    check("del7_addr", ad, 7);
    check("del7_count", count, 31);
    do_req(2'd1, 64'h777, 0, st, ad, lat);
    check("reins7_status", st, 0);
    check("reins7_addr", ad, 7);
    check("reins7_count", count, 32);

    // Misses and reserved op
    do_req(2'd0, 64'h555, 0, st, ad, lat);
    check("lkp_miss_status", st, 1);
    check("lkp_miss_addr", ad, 0);
    do_req(2'd0, 64'h777, 0, st, ad, lat);
    check("lkp_777_addr", ad, 7);
    we0 = we_cnt;
    do_req(2'd2, 64'h555, 0, st, ad, lat);
    check("del_miss_status", st, 1);
    check("del_miss_writes", we_cnt - we0, 0);
    check("del_miss_count", count, 32);
    we0 = we_cnt;
    do_req(2'd3, 64'hA5, 0, st, ad, lat);
    check("op3_status", st, 3);
    check("op3_addr", ad, 0);
    check("op3_writes", we_cnt - we0, 0);

    // Back-pressured delete
    do_req(2'd2, 64'h777, 5, st, ad, lat);
    check("bp_del_status", st, 0);
    check("bp_del_addr", ad, 7);
    check("bp_del_count", count, 31);

    // Reset while waiting on the CAM write
    @(negedge clk);
    req_valid = 1'b1; req_op = 2'd1; req_key = 64'h888;
    for (int n = 0; n < 200 && !req_ready; n++) @(negedge clk);
    @(posedge clk); #1 req_valid = 1'b0;
    for (int n = 0; n < 20 && !cam_write_enable; n++) @(negedge clk);
    check("rstwait_we_seen", cam_write_enable, 1);
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b1;
    @(posedge clk); @(posedge clk); #1;
    rst = 1'b0;
    check("rstwait_count", count, 0);
    ok = 1'b1;
    repeat (20) begin
      @(negedge clk);
      if (resp_valid) ok = 1'b0;
    end
    check("rstwait_no_resp", ok, 1);
    do_req(2'd1, 64'hBEEF, 0, st, ad, lat);
    check("post_rst_status", st, 0);
    check("post_rst_addr", ad, 0);
    check("post_rst_count", count, 1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL global_timeout: got no finish, expected finish before 500us");
    $fatal(1, "timeout");
  end
endmodule

// File: doc/cam_table_ctrl.md
CAM_TABLE_CTRL -- requirements
Module: cam_table_ctrl

Interface
REQ-001 SHALL have parameter DATA_WIDTH, default 64: key width, equal to the CAM data width.
REQ-002 SHALL have parameter ADDR_WIDTH, default 5: CAM address width; table holds 2**ADDR_WIDTH entries.
REQ-003 SHALL have port clk, input, 1: clock; all logic on its rising edge.
REQ-004 SHALL have port rst, input, 1: reset, synchronous, active-high.
REQ-005 SHALL have port req_valid, input, 1: request valid.
REQ-006 SHALL have port req_ready, output, 1: request accepted when req_valid and req_ready are both 1.
REQ-007 SHALL have port req_op, input, 2: 0 LOOKUP, 1 INSERT, 2 DELETE, 3 reserved.
REQ-008 SHALL have port req_key, input, DATA_WIDTH: key.
REQ-009 SHALL have ports resp_valid (output, 1) and resp_ready (input, 1): response handshake.
REQ-010 SHALL have port resp_status, output, 2: 0 OK, 1 NOTFOUND, 2 EXISTS, 3 FULL/ILLEGAL.
REQ-011 SHALL have port resp_addr, output, ADDR_WIDTH: entry address for the response.
REQ-012 SHALL have port count, output, ADDR_WIDTH+1: number of valid entries.
REQ-013 SHALL have CAM-side outputs: cam_write_addr (ADDR_WIDTH), cam_write_data (DATA_WIDTH), cam_write_delete (1), cam_write_enable (1), cam_compare_data (DATA_WIDTH).
REQ-014 SHALL have CAM-side inputs: cam_write_busy (1), cam_match (1), cam_match_addr (ADDR_WIDTH); match outputs are valid one cycle after cam_compare_data changes.

Function
REQ-015 SHALL implement states IDLE, CMP, EVAL, ISSUE, SETTLE, WAIT, RESP.
REQ-016 SHALL assert req_ready only when in IDLE and cam_write_busy=0.
REQ-017 SHALL, on accept, register req_op and req_key into key_reg, and transition IDLE->CMP.
REQ-018 SHALL drive cam_compare_data=key_reg continuously.
REQ-019 SHALL transition CMP->EVAL unconditionally and sample cam_match/cam_match_addr in EVAL.
REQ-020 SHALL, for LOOKUP in EVAL: status OK with addr=cam_match_addr on hit, NOTFOUND with addr=0 on miss; go to RESP.
REQ-021 SHALL, for INSERT in EVAL: on hit, status EXISTS with addr=cam_match_addr, go to RESP; else if count==2**ADDR_WIDTH, status FULL with addr=0, go to RESP; else select the lowest-index clear bit of the valid bitmap as alloc_addr and go to ISSUE.
REQ-022 SHALL, for DELETE in EVAL: on miss, status NOTFOUND, go to RESP; on hit, target cam_match_addr, go to ISSUE.
REQ-023 SHALL, for op 3, respond FULL/ILLEGAL with addr=0 after EVAL, without touching the CAM.
REQ-024 SHALL, in ISSUE, hold cam_write_addr/data/delete stable and assert cam_write_enable for exactly one cycle once cam_write_busy=0, then go to SETTLE.
REQ-025 SHALL keep cam_write_enable=0 in every state other than ISSUE.
REQ-026 SHALL pass through SETTLE for one cycle, ignoring busy, then stay in WAIT until cam_write_busy=0.
REQ-027 SHALL, on leaving WAIT, set (INSERT) or clear (DELETE) the bitmap bit, increment or decrement count, report status OK with the written address, and go to RESP.
REQ-028 SHALL hold resp_valid=1 and keep resp_* stable in RESP until resp_ready=1, then return to IDLE.
REQ-029 SHALL give a LOOKUP accepted at edge T resp_valid=1 after edge T+3; requests are processed strictly one at a time, in order.
REQ-030 SHALL keep count equal to the popcount of the valid bitmap, never exceeding 2**ADDR_WIDTH and never underflowing.

Reset
REQ-031 SHALL, while rst=1, set state IDLE, clear the bitmap, and force count=0, resp_valid=0, cam_write_enable=0, cam_write_delete=0, resp_status=0, resp_addr=0, cam_write_addr=0, cam_write_data=0, and key_reg=0.
REQ-032 SHALL discard any in-flight operation or pending response on reset; the CAM is reset by the same rst and re-initialises, with cam_write_busy=1 holding req_ready low.

Verification
REQ-033 SHALL cover: reset, then hold cam_write_busy=1 for 16 cycles -> req_ready=0 throughout, count=0, then req_ready=1.
REQ-034 SHALL cover: INSERT key 0xA5 into an empty table -> OK, addr 0, count 1; then LOOKUP 0xA5 -> OK, addr 0, resp_valid after edge T+3.
REQ-035 SHALL cover: INSERT 0xA5 again -> EXISTS, addr 0, no cam_write_enable pulse, count unchanged.
REQ-036 SHALL cover: fill all 32 entries, then INSERT a new key -> FULL; DELETE the key at addr 7, then INSERT -> OK, addr 7.
REQ-037 SHALL cover: DELETE an absent key -> NOTFOUND, no CAM write; DELETE with resp_ready held low 5 cycles -> resp stable, req_ready=0.
REQ-038 SHALL cover: assert rst during WAIT -> resp_valid never asserts, count=0, bitmap cleared.
